// File: rtl/mcdf_arb_pkg.sv
// Shared widths, FSM state type and slave bus payload for the MCDF arbiter.
package mcdf_arb_pkg;

  localparam int unsigned CH_NUM   = 3;
  localparam int unsigned PRIO_W   = 2;
  localparam int unsigned PKGLEN_W = 3;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ID_W     = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [DATA_W-1:0]   data;
    logic [PKGLEN_W-1:0] pkglen;
    logic                val;
    logic                last;
  } slv_bus_t;

endpackage

// File: rtl/arb_prio_sel.sv
// Combinational winner picker: lowest prio value wins, ties searched from (last_id + 1) mod CH_NUM.
module arb_prio_sel
  import mcdf_arb_pkg::*;
(
  input  logic [CH_NUM-1:0]             req,
  input  logic [CH_NUM-1:0][PRIO_W-1:0] prio,
  input  logic [ID_W-1:0]               last_id,
  output logic [ID_W-1:0]               win_id,
  output logic                          win_val
);

  logic [PRIO_W-1:0] best;
  logic [ID_W-1:0]   start;
  logic [ID_W-1:0]   idx;
  logic              found;

  always_comb begin
    best    = '1;
    start   = '0;
    idx     = '0;
    found   = 1'b0;
    win_id  = '0;
    win_val = |req;

    for (int unsigned i = 0; i < CH_NUM; i++) begin
      if (req[i] && (prio[i] <= best)) begin
        best = prio[i];
      end
    end

    start = (last_id >= ID_W'(CH_NUM - 1)) ? '0 : last_id + ID_W'(1);

    // Walk channels circularly from start; first requester at best prio wins.
    for (int unsigned k = 0; k < CH_NUM; k++) begin
      idx = start + ID_W'(k);
      if (idx >= ID_W'(CH_NUM)) begin
        idx = idx - ID_W'(CH_NUM);
      end
      if (!found && req[idx] && (prio[idx] == best)) begin
        win_id = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mcdf_arbiter.sv
// Three-channel MCDF arbiter between slave FIFOs and formatter.
// Build option: ARBITER_RR_TIE_EN rotates equal-priority ties from the last granted channel.
module mcdf_arbiter
  import mcdf_arb_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [PRIO_W-1:0]   slv0_prio_i,
  input  logic [PRIO_W-1:0]   slv1_prio_i,
  input  logic [PRIO_W-1:0]   slv2_prio_i,
  input  logic [PKGLEN_W-1:0] slv0_pkglen_i,
  input  logic [PKGLEN_W-1:0] slv1_pkglen_i,
  input  logic [PKGLEN_W-1:0] slv2_pkglen_i,
  input  logic [DATA_W-1:0]   slv0_data_i,
  input  logic [DATA_W-1:0]   slv1_data_i,
  input  logic [DATA_W-1:0]   slv2_data_i,
  input  logic                slv0_req_i,
  input  logic                slv1_req_i,
  input  logic                slv2_req_i,
  input  logic                slv0_val_i,
  input  logic                slv1_val_i,
  input  logic                slv2_val_i,
  input  logic                slv0_end_i,
  input  logic                slv1_end_i,
  input  logic                slv2_end_i,
  input  logic                f2a_id_req_i,
  input  logic                f2a_ack_i,
  output logic                a2s0_ack_o,
  output logic                a2s1_ack_o,
  output logic                a2s2_ack_o,
  output logic                a2f_val_o,
  output logic [ID_W-1:0]     a2f_id_o,
  output logic [DATA_W-1:0]   a2f_data_o,
  output logic [PKGLEN_W-1:0] a2f_pkglen_sel_o,
  output logic                a2f_end_o
);

  arb_state_e                    state_q, state_d;
  logic [ID_W-1:0]               id_q, id_d;
  logic [ID_W-1:0]               rr_last;
  logic [ID_W-1:0]               win_id;
  logic                          win_val;
  logic [CH_NUM-1:0]             req_vec;
  logic [CH_NUM-1:0][PRIO_W-1:0] prio_vec;
  slv_bus_t                      sel;

  assign req_vec  = {slv2_req_i, slv1_req_i, slv0_req_i};
  assign prio_vec = {slv2_prio_i, slv1_prio_i, slv0_prio_i};
  assign a2f_id_o = id_q;

  // Feeding the last channel index makes the picker's search start at channel 0.
`ifdef ARBITER_RR_TIE_EN
  assign rr_last = id_q;
`else
  assign rr_last = ID_W'(CH_NUM - 1);
`endif

  arb_prio_sel u_prio_sel (
    .req     (req_vec),
    .prio    (prio_vec),
    .last_id (rr_last),
    .win_id  (win_id),
    .win_val (win_val)
  );

  // Selected channel bus, keyed by the id register.
  always_comb begin
    case (id_q)
      ID_W'(1): sel = '{data: slv1_data_i, pkglen: slv1_pkglen_i, val: slv1_val_i, last: slv1_end_i};
      ID_W'(2): sel = '{data: slv2_data_i, pkglen: slv2_pkglen_i, val: slv2_val_i, last: slv2_end_i};
      default:  sel = '{data: slv0_data_i, pkglen: slv0_pkglen_i, val: slv0_val_i, last: slv0_end_i};
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    id_d             = id_q;
    a2f_val_o        = 1'b0;
    a2f_end_o        = 1'b0;
    a2f_data_o       = '0;
    a2s0_ack_o       = 1'b0;
    a2s1_ack_o       = 1'b0;
    a2s2_ack_o       = 1'b0;
    a2f_pkglen_sel_o = sel.pkglen;

    case (state_q)
      IDLE: begin
        if (f2a_id_req_i && win_val) begin
          state_d = GRANT;
          id_d    = win_id;
        end
      end
      GRANT: begin
        a2f_val_o  = sel.val;
        a2f_end_o  = sel.last;
        a2f_data_o = sel.data;
        a2s0_ack_o = f2a_ack_i && (id_q == ID_W'(0));
        a2s1_ack_o = f2a_ack_i && (id_q == ID_W'(1));
        a2s2_ack_o = f2a_ack_i && (id_q == ID_W'(2));
        // End without valid is not a real last beat.
        if (sel.val && sel.last) begin
          state_d = IDLE;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_mcdf_arbiter.sv
// Scoreboard bench for mcdf_arbiter: directed plan plus random traffic against a behavioural model.
module tb_mcdf_arbiter;

  typedef struct packed {
    logic [2:0]  acks;
    logic        val;
    logic        endb;
    logic [1:0]  id;
    logic [2:0]  pkglen;
    logic [31:0] data;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  prio   [3];
  logic [2:0]  pkglen [3];
  logic [31:0] data   [3];
  logic [2:0]  req, val, endb;
  logic        id_req, ack;
  logic        ack0, ack1, ack2, a_val, a_end;
  logic [1:0]  a_id;
  logic [31:0] a_data;
  logic [2:0]  a_pkglen;

  int   n_checks = 0;
  int   n_fail   = 0;
  obs_t exp_q[$];

  bit   m_known = 1'b0;
  bit   m_grant = 1'b0;
  int   m_id    = 0;

  always #5 clk = ~clk;

  mcdf_arbiter dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .slv0_prio_i      (prio[0]),
    .slv1_prio_i      (prio[1]),
    .slv2_prio_i      (prio[2]),
    .slv0_pkglen_i    (pkglen[0]),
    .slv1_pkglen_i    (pkglen[1]),
    .slv2_pkglen_i    (pkglen[2]),
    .slv0_data_i      (data[0]),
    .slv1_data_i      (data[1]),
    .slv2_data_i      (data[2]),
    .slv0_req_i       (req[0]),
    .slv1_req_i       (req[1]),
    .slv2_req_i       (req[2]),
    .slv0_val_i       (val[0]),
    .slv1_val_i       (val[1]),
    .slv2_val_i       (val[2]),
    .slv0_end_i       (endb[0]),
    .slv1_end_i       (endb[1]),
    .slv2_end_i       (endb[2]),
    .f2a_id_req_i     (id_req),
    .f2a_ack_i        (ack),
    .a2s0_ack_o       (ack0),
    .a2s1_ack_o       (ack1),
    .a2s2_ack_o       (ack2),
    .a2f_val_o        (a_val),
    .a2f_id_o         (a_id),
    .a2f_data_o       (a_data),
    .a2f_pkglen_sel_o (a_pkglen),
    .a2f_end_o        (a_end)
  );

  // Winner = lowest prio among requesters; equal-prio candidates ordered by channel or rotation.
  function automatic int pick();
    int best = 4;
    int cand[$];
    int choice;
    for (int i = 0; i < 3; i++) if (req[i] && int'(prio[i]) < best) best = int'(prio[i]);
    for (int i = 0; i < 3; i++) if (req[i] && int'(prio[i]) == best) cand.push_back(i);
    choice = cand[0];
`ifdef ARBITER_RR_TIE_EN
    foreach (cand[k]) begin
      if ((cand[k] - m_id + 2) % 3 < (choice - m_id + 2) % 3) choice = cand[k];
    end
`endif
    return choice;
  endfunction

  function automatic obs_t expect_now();
    obs_t e;
    e        = '0;
    e.id     = 2'(m_id);
    e.pkglen = pkglen[m_id];
    if (m_grant) begin
      e.val        = val[m_id];
      e.endb       = endb[m_id];
      e.data       = data[m_id];
      e.acks[m_id] = ack;
    end
    return e;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.acks   = {ack2, ack1, ack0};
    o.val    = a_val;
    o.endb   = a_end;
    o.id     = a_id;
    o.pkglen = a_pkglen;
    o.data   = a_data;
    return o;
  endfunction

  task automatic model_update();
    if (rst) begin
      m_known = 1'b1;
      m_grant = 1'b0;
      m_id    = 0;
    end else if (m_known) begin
      if (!m_grant) begin
        if (id_req && (req != 3'b000)) begin
          m_id    = pick();
          m_grant = 1'b1;
        end
      end else if (val[m_id] && endb[m_id]) begin
        m_grant = 1'b0;
      end
    end
  endtask

  // Inputs are already applied; queue this cycle's expected outputs, then clock once.
  task automatic step();
    if (m_known) exp_q.push_back(expect_now());
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < 3; i++) data[i] = $urandom;
  endtask

  // Monitor: compare DUT outputs with the queued expectation on each falling edge.
  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = observe();
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL scoreboard t=%0t: got ack=%b val=%b end=%b id=%0d pkglen=%0d data=%h expected ack=%b val=%b end=%b id=%0d pkglen=%0d data=%h",
                   $time, a.acks, a.val, a.endb, a.id, a.pkglen, a.data,
                   e.acks, e.val, e.endb, e.id, e.pkglen, e.data);
        end
      end
    end
  end

  initial begin
    int first_id;
    rst = 1'b1; req = '0; val = '0; endb = '0; id_req = 1'b0; ack = 1'b0;
    prio = '{2'd0, 2'd0, 2'd0}; pkglen = '{3'd0, 3'd0, 3'd0}; data = '{32'd0, 32'd0, 32'd0};
    step(); step();
    rst = 1'b0;
    check("reset_id", int'(a_id), 0);

    // Tie between ch1/ch2 at prio 1 goes to ch1; ack routed only to ch1.
    prio = '{2'd3, 2'd1, 2'd1}; pkglen = '{3'd2, 3'd1, 3'd0}; req = 3'b111; id_req = 1'b1;
    step();
    id_req = 1'b0;
    check("tp1_id", int'(a_id), 1);
    check("tp1_pkglen", int'(a_pkglen), 1);
    ack = 1'b1; #1;
    check("tp1_ack1", int'(ack1), 1);
    check("tp1_ack0", int'(ack0), 0);
    check("tp1_ack2", int'(ack2), 0);
    step();
    ack = 1'b0;

    // End without valid plus a stray id request must not disturb the grant.
    val = 3'b000; endb = 3'b010; id_req = 1'b1; rand_data();
    step();
    check("tp5_id", int'(a_id), 1);
    for (int b = 0; b < 8; b++) begin
      rand_data();
      val    = 3'b010 | (3'($urandom) & 3'b101);
      endb   = (b == 7) ? 3'b010 : (3'($urandom) & 3'b101);
      id_req = 1'($urandom);
      ack    = 1'($urandom);
      #1;
      check("tp2_data", int'(a_data == data[1]), 1);
      step();
    end
    val = '0; endb = '0; id_req = 1'b0; ack = 1'b0;
    check("tp2_idle_val", int'(a_val), 0);
    step();

    // Different prios: ch0 (prio 2) beats ch2 (prio 3), ch1 not requesting.
    prio = '{2'd2, 2'd0, 2'd3}; req = 3'b101; id_req = 1'b1;
    step();
    id_req = 1'b0;
    check("tp3_id", int'(a_id), 0);
    val = 3'b001; endb = 3'b001; step();
    val = '0; endb = '0;

    // Grant ch2, release, then an id request with nobody requesting is ignored.
    prio = '{2'd3, 2'd3, 2'd0}; req = 3'b100; id_req = 1'b1; step();
    id_req = 1'b0; val = 3'b100; endb = 3'b100; step();
    val = '0; endb = '0; req = '0; id_req = 1'b1; ack = 1'b1;
    repeat (3) step();
    check("tp4_id_hold", int'(a_id), 2);
    check("tp4_no_ack", int'({ack2, ack1, ack0}), 0);
    id_req = 1'b0; ack = 1'b0;

    // Reset mid-package drops the grant.
    prio = '{2'd1, 2'd0, 2'd2}; req = 3'b111; id_req = 1'b1; step();
    id_req = 1'b0;
    check("tp6_id", int'(a_id), 1);
    val = 3'b111; rand_data(); step();
    rst = 1'b1; step();
    rst = 1'b0;
    check("tp6_rst_id", int'(a_id), 0);
    check("tp6_rst_val", int'(a_val), 0);
    check("tp6_rst_data", int'(a_data == 32'd0), 1);
    val = '0;

    // Back-to-back equal-priority grants.
    prio = '{2'd1, 2'd1, 2'd1}; req = 3'b111; id_req = 1'b1; step();
    id_req = 1'b0;
    first_id = int'(a_id);
    val = 3'(1 << m_id); endb = 3'(1 << m_id); step();
    val = '0; endb = '0; id_req = 1'b1; step();
    id_req = 1'b0;
`ifdef ARBITER_RR_TIE_EN
    check("rr_first", first_id, 1);
    check("rr_second", int'(a_id), 2);
`else
    check("tie_first", first_id, 0);
    check("tie_second", int'(a_id), 0);
`endif

    // Random traffic.
    repeat (3000) begin
      rst = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < 3; i++) begin
          prio[i]   = 2'($urandom);
          pkglen[i] = 3'($urandom);
        end
      end
      rand_data();
      req    = 3'($urandom);
      val    = 3'($urandom);
      endb   = 3'($urandom) & 3'($urandom);
      id_req = 1'($urandom);
      ack    = 1'($urandom);
      step();
    end

    rst = 1'b0;
    @(negedge clk); #1;
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mcdf_arbiter.md
# mcdf_arbiter

Three-channel arbiter of the MCDF datapath, between the three slave channel FIFOs and the formatter. On a formatter ID request it picks the highest-priority requesting slave. It then muxes that slave's data, valid, end and package-length onto the formatter interface and routes the formatter's acknowledge back to that slave only. The grant is held until the selected slave signals end of package.

## Interface
Parameters: none; widths come from the shared package.
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  one clock; reset is synchronous and active-high
- slv0_prio_i, slv1_prio_i, slv2_prio_i  in  2  channel priority, 0 = highest
- slv0_pkglen_i, slv1_pkglen_i, slv2_pkglen_i  in  3  package-length select per channel
- slv0_data_i, slv1_data_i, slv2_data_i  in  32  channel data
- slv0_req_i, slv1_req_i, slv2_req_i  in  1  channel requests service
- slv0_val_i, slv1_val_i, slv2_val_i  in  1  channel data valid
- slv0_end_i, slv1_end_i, slv2_end_i  in  1  last beat of package
- f2a_id_req_i  in  1  formatter requests a new channel ID
- f2a_ack_i  in  1  formatter acknowledge
- a2s0_ack_o, a2s1_ack_o, a2s2_ack_o  out  1  acknowledge to each slave
- a2f_val_o  out  1  selected channel valid
- a2f_id_o  out  2  granted channel number, 0..2
- a2f_data_o  out  32  selected channel data
- a2f_pkglen_sel_o  out  3  selected channel pkglen
- a2f_end_o  out  1  selected channel end

## Operation
- Two-state FSM, IDLE and GRANT; reset enters IDLE.
- IDLE → GRANT when f2a_id_req_i=1 and any slvX_req_i=1. The winner is registered into the id register (drives a2f_id_o).
- In IDLE, f2a_id_req_i with no request is ignored; the FSM stays in IDLE.
- Winner is the lowest prio value among requesting channels. Ties go to the lowest channel index, unless the macro below is enabled.
- GRANT → IDLE when the selected channel has val_i=1 and end_i=1 in the same cycle. end_i without val_i is ignored.
- f2a_id_req_i is ignored while in GRANT.
- a2sX_ack_o = f2a_ack_i when in GRANT and a2f_id_o==X; otherwise 0. Combinational.
- In GRANT, a2f_val_o, a2f_end_o and a2f_data_o are combinational muxes of the selected channel's inputs. In IDLE they are forced to 0.
- a2f_pkglen_sel_o always shows the pkglen of the channel in a2f_id_o, so it stays valid after grant for the formatter.
- The id register holds its value in IDLE until the next grant.
- Requests from non-selected channels have no effect during GRANT.

## Timing
- Reset values: state IDLE, a2f_id_o=0, a2f_val_o=0, a2f_end_o=0, a2f_data_o=0, all a2sX_ack_o=0, a2f_pkglen_sel_o=slv0_pkglen_i.
- Grant latency: f2a_id_req_i sampled at edge N → a2f_id_o valid and GRANT state after edge N.
- Data path latency: 0 cycles, input-to-output combinational.
- Release: end+val sampled at edge M → IDLE after edge M. A new f2a_id_req_i is accepted from edge M+1.
- rst_i asserted during GRANT → IDLE with all reset values at the next edge; any package in flight is dropped.

## Configuration
- ARBITER_RR_TIE_EN defined: among requesters with equal best priority, the search starts at (last granted id + 1) mod 3. The pointer resets to 0, so after reset the search starts at channel 1.
- Not defined: equal-priority ties resolve to the lowest channel index.
- Strict priority between different prio values holds in both cases.

## Structure
- Package mcdf_arb_pkg holds:
  - CH_NUM=3, PRIO_W=2, PKGLEN_W=3, DATA_W=32, ID_W=2
  - state enum {IDLE, GRANT}
- Sub-module arb_prio_sel: combinational picker. Inputs: req vector, prio vector, last id. Output: winner id and a valid flag.

## Test plan
- Prios 3/1/1, pkglen 2/1/0, all req=1, f2a_id_req_i pulse → a2f_id_o=1, a2f_pkglen_sel_o=1. Then f2a_ack_i pulse → only a2s1_ack_o=1.
- Same grant, 8 beats of slv1_val_i=1 with random data → a2f_data_o tracks slv1_data_i each cycle, a2f_val_o=1. end on last beat → IDLE next cycle, a2f_val_o=0.
- Prios 2/0/3, only ch0 and ch2 request → grant id=0; ch1 prio irrelevant.
- f2a_id_req_i with all req=0 → stays IDLE, a2f_id_o unchanged, no acks.
- Second f2a_id_req_i mid-package, and slv1_end_i=1 with val=0 → grant unchanged.
- rst_i during GRANT → IDLE, a2f_id_o=0, outputs 0. With ARBITER_RR_TIE_EN defined, two back-to-back grants at prios 1/1/1 → ids 1 then 2.
